// File: rtl/mem_pkg.sv
// Shared types for the memory responder.
//   state_e : responder FSM states
//   sel_e   : which initiator port owns the current transaction
//   LAT_W   : width of the wait-state counter
package mem_pkg;

    localparam int unsigned LAT_W = 4;

    typedef enum logic [2:0] {
        StIdle,
        StWait,
        StByte,
        StResp,
        StTurn
    } state_e;

    typedef enum logic {
        SelInst,
        SelData
    } sel_e;

endpackage

// File: rtl/byte_ram.sv
// Byte-wide backing store, 2^M_WIDTH entries.
// Synchronous write, asynchronous read, single shared address.
//   clk   : clock
//   we    : write enable
//   addr  : byte address (read and write)
//   wdata : write data
//   rdata : read data at addr
module byte_ram #(
    parameter int unsigned M_WIDTH = 8
) (
    input  logic               clk,
    input  logic               we,
    input  logic [M_WIDTH-1:0] addr,
    input  logic [M_WIDTH-1:0] wdata,
    output logic [M_WIDTH-1:0] rdata
);

    logic [M_WIDTH-1:0] mem [2**M_WIDTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    assign rdata = mem[addr];

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder serving an instruction port and a data port from one
// byte-wide store. Round-robin arbitration, LATENCY wait states per byte
// access, 16-bit big-endian instruction assembly from two byte reads.
//   clk, rst             : clock, synchronous active-low reset
//   i_req/i_addr         : instruction fetch request and byte address
//   i_data/i_ready       : assembled instruction, one-cycle completion pulse
//   d_req/d_we/d_addr    : data request, write select, byte address
//   d_wdata              : write data
//   d_rdata/d_ready      : read data, one-cycle completion pulse
module mem_responder
    import mem_pkg::*;
#(
    parameter int unsigned M_WIDTH    = 8,
    parameter int unsigned INST_WIDTH = 16,
    parameter int unsigned LATENCY    = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_req,
    input  logic [M_WIDTH-1:0]    i_addr,
    output logic [INST_WIDTH-1:0] i_data,
    output logic                  i_ready,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [M_WIDTH-1:0]    d_addr,
    input  logic [M_WIDTH-1:0]    d_wdata,
    output logic [M_WIDTH-1:0]    d_rdata,
    output logic                  d_ready
);

    localparam logic [LAT_W-1:0] LAT = LAT_W'(LATENCY);
    // With no wait states the access cycle follows the grant directly.
    localparam state_e ACCESS_ST = (LATENCY > 0) ? StWait : StByte;

    state_e                state_q, state_d;
    sel_e                  sel_q, sel_d;
    sel_e                  last_q, last_d;
    logic [LAT_W-1:0]      cnt_q, cnt_d;
    logic [M_WIDTH-1:0]    addr_q, addr_d;
    logic                  we_q, we_d;
    logic [M_WIDTH-1:0]    wdata_q, wdata_d;
    logic                  idx_q, idx_d;
    logic [INST_WIDTH-1:0] i_data_q, i_data_d;
    logic [M_WIDTH-1:0]    d_rdata_q, d_rdata_d;

    logic [M_WIDTH-1:0]    ram_addr;
    logic [M_WIDTH-1:0]    ram_rdata;
    logic                  ram_we;

    // Second instruction byte reads addr+1; the adder wraps modulo 2^M_WIDTH.
    assign ram_addr = addr_q + {{(M_WIDTH-1){1'b0}}, idx_q};
    // Gate on rst so a write landing on a reset edge is not committed.
    assign ram_we   = rst && (state_q == StByte) && (sel_q == SelData) && we_q;

    byte_ram #(
        .M_WIDTH (M_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (wdata_q),
        .rdata (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q   <= StIdle;
            sel_q     <= SelInst;
            last_q    <= SelData;
            cnt_q     <= '0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            idx_q     <= 1'b0;
            i_data_q  <= '0;
            d_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            last_q    <= last_d;
            cnt_q     <= cnt_d;
            addr_q    <= addr_d;
            we_q      <= we_d;
            wdata_q   <= wdata_d;
            idx_q     <= idx_d;
            i_data_q  <= i_data_d;
            d_rdata_q <= d_rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        last_d    = last_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        idx_d     = idx_q;
        i_data_d  = i_data_q;
        d_rdata_d = d_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (i_req || d_req) begin
                    if (i_req && d_req) begin
                        sel_d = (last_q == SelData) ? SelInst : SelData;
                    end else begin
                        sel_d = i_req ? SelInst : SelData;
                    end
                    addr_d  = (sel_d == SelInst) ? i_addr : d_addr;
                    we_d    = (sel_d == SelData) && d_we;
                    wdata_d = d_wdata;
                    idx_d   = 1'b0;
                    cnt_d   = LAT;
                    state_d = ACCESS_ST;
                end
            end
            StWait: begin
                cnt_d = cnt_q - 1'b1;
                if (cnt_q <= 1) begin
                    state_d = StByte;
                end
            end
            StByte: begin
                if (sel_q == SelData) begin
                    if (!we_q) begin
                        d_rdata_d = ram_rdata;
                    end
                    state_d = StResp;
                end else if (!idx_q) begin
                    i_data_d[INST_WIDTH-1 -: M_WIDTH] = ram_rdata;
                    idx_d   = 1'b1;
                    cnt_d   = LAT;
                    state_d = ACCESS_ST;
                end else begin
                    i_data_d[M_WIDTH-1:0] = ram_rdata;
                    state_d = StResp;
                end
            end
            StResp: begin
                last_d  = sel_q;
                state_d = StTurn;
            end
            StTurn: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign i_ready = (state_q == StResp) && (sel_q == SelInst);
    assign d_ready = (state_q == StResp) && (sel_q == SelData);
    assign i_data  = i_data_q;
    assign d_rdata = d_rdata_q;

endmodule

// File: tb/tb_mem_responder.sv
module tb_mem_responder;

    logic        clk;
    logic        rst;
    logic        i_req   [2];
    logic [7:0]  i_addr  [2];
    logic [15:0] i_data  [2];
    logic        i_ready [2];
    logic        d_req   [2];
    logic        d_we    [2];
    logic [7:0]  d_addr  [2];
    logic [7:0]  d_wdata [2];
    logic [7:0]  d_rdata [2];
    logic        d_ready [2];

    int total = 0;
    int bad   = 0;

    // Unit 0: LATENCY=2, unit 1: LATENCY=0.
    mem_responder #(.M_WIDTH(8), .INST_WIDTH(16), .LATENCY(2)) u_dut0 (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req[0]),
        .i_addr  (i_addr[0]),
        .i_data  (i_data[0]),
        .i_ready (i_ready[0]),
        .d_req   (d_req[0]),
        .d_we    (d_we[0]),
        .d_addr  (d_addr[0]),
        .d_wdata (d_wdata[0]),
        .d_rdata (d_rdata[0]),
        .d_ready (d_ready[0])
    );

    mem_responder #(.M_WIDTH(8), .INST_WIDTH(16), .LATENCY(0)) u_dut1 (
        .clk     (clk),
        .rst     (rst),
        .i_req   (i_req[1]),
        .i_addr  (i_addr[1]),
        .i_data  (i_data[1]),
        .i_ready (i_ready[1]),
        .d_req   (d_req[1]),
        .d_we    (d_we[1]),
        .d_addr  (d_addr[1]),
        .d_wdata (d_wdata[1]),
        .d_rdata (d_rdata[1]),
        .d_ready (d_ready[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called in an IDLE cycle; returns the ready-cycle index (grant cycle = 0).
    task automatic data_acc(input int u, input logic we, input logic [7:0] a,
                            input logic [7:0] wd, output int lat, output logic [7:0] rd);
        int n;
        d_req[u] = 1'b1; d_we[u] = we; d_addr[u] = a; d_wdata[u] = wd;
        n = 0;
        do begin
            tick();
            n++;
        end while (!d_ready[u] && n < 60);
        lat = n;
        rd  = d_rdata[u];
        d_req[u] = 1'b0; d_we[u] = 1'b0;
        tick();
        check("d_ready_one_cycle", {31'd0, d_ready[u]}, 32'd0);
        tick();
    endtask

    task automatic inst_fetch(input int u, input logic [7:0] a,
                              output int lat, output logic [15:0] ins);
        int n;
        i_req[u] = 1'b1; i_addr[u] = a;
        n = 0;
        do begin
            tick();
            n++;
        end while (!i_ready[u] && n < 60);
        lat = n;
        ins = i_data[u];
        i_req[u] = 1'b0;
        tick();
        check("i_ready_one_cycle", {31'd0, i_ready[u]}, 32'd0);
        tick();
    endtask

    initial begin
        int          lat;
        int          k;
        int          n;
        int          first;
        int          misses;
        logic [7:0]  rd;
        logic [15:0] ins;
        logic        order [4];

        for (int u = 0; u < 2; u++) begin
            i_req[u] = 1'b0; i_addr[u] = '0;
            d_req[u] = 1'b0; d_we[u] = 1'b0; d_addr[u] = '0; d_wdata[u] = '0;
        end
        rst = 1'b0;
        repeat (3) tick();
        rst = 1'b1;

        check("rst_i_ready", {31'd0, i_ready[0]}, 32'd0);
        check("rst_d_ready", {31'd0, d_ready[0]}, 32'd0);
        check("rst_i_data", {16'd0, i_data[0]}, 32'd0);
        check("rst_d_rdata", {24'd0, d_rdata[0]}, 32'd0);
        check("rst_i_data_l0", {16'd0, i_data[1]}, 32'd0);

        // Tie straight after reset, both held: INST, DATA, INST, DATA.
        i_req[0] = 1'b1; i_addr[0] = 8'h40;
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 8'h41; d_wdata[0] = 8'h99;
        k = 0; n = 0; first = 0;
        order[0] = 1'b1; order[1] = 1'b1; order[2] = 1'b1; order[3] = 1'b1;
        while (k < 4 && n < 200) begin
            tick();
            n++;
            if (i_ready[0]) begin
                order[k] = 1'b0;
                if (k == 0) first = n;
                k++;
            end else if (d_ready[0]) begin
                order[k] = 1'b1;
                k++;
            end
        end
        i_req[0] = 1'b0; d_req[0] = 1'b0; d_we[0] = 1'b0;
        tick(); tick();
        check("tie_count", k, 4);
        check("tie_first_lat", first, 7);
        check("tie_0_inst", {31'd0, order[0]}, 32'd0);
        check("tie_1_data", {31'd0, order[1]}, 32'd1);
        check("tie_2_inst", {31'd0, order[2]}, 32'd0);
        check("tie_3_data", {31'd0, order[3]}, 32'd1);

        // Writes then a big-endian fetch.
        data_acc(0, 1'b1, 8'h10, 8'hAB, lat, rd);
        check("wr10_lat", lat, 4);
        data_acc(0, 1'b1, 8'h11, 8'hCD, lat, rd);
        check("wr11_lat", lat, 4);
        inst_fetch(0, 8'h10, lat, ins);
        check("fetch10_lat", lat, 7);
        check("fetch10_data", {16'd0, ins}, 32'h0000ABCD);
        repeat (3) tick();
        check("fetch10_held", {16'd0, i_data[0]}, 32'h0000ABCD);

        // Address wrap on second byte.
        data_acc(0, 1'b1, 8'hFF, 8'h12, lat, rd);
        data_acc(0, 1'b1, 8'h00, 8'h34, lat, rd);
        inst_fetch(0, 8'hFF, lat, ins);
        check("fetchFF_wrap", {16'd0, ins}, 32'h00001234);

        // Reads update d_rdata, writes do not.
        data_acc(0, 1'b0, 8'h10, 8'h00, lat, rd);
        check("rd10_lat", lat, 4);
        check("rd10_data", {24'd0, rd}, 32'h000000AB);
        data_acc(0, 1'b1, 8'h20, 8'h55, lat, rd);
        check("wr20_rdata_kept", {24'd0, d_rdata[0]}, 32'h000000AB);

        // Reset during WAIT aborts a write.
        data_acc(0, 1'b1, 8'h30, 8'h66, lat, rd);
        d_req[0] = 1'b1; d_we[0] = 1'b1; d_addr[0] = 8'h30; d_wdata[0] = 8'h77;
        tick();
        tick();
        rst = 1'b0;
        tick();
        rst = 1'b1;
        d_req[0] = 1'b0; d_we[0] = 1'b0;
        check("abort_d_rdata", {24'd0, d_rdata[0]}, 32'd0);
        check("abort_i_data", {16'd0, i_data[0]}, 32'd0);
        misses = 0;
        for (int c = 0; c < 8; c++) begin
            if (d_ready[0]) misses++;
            tick();
        end
        check("abort_no_ready", misses, 0);
        data_acc(0, 1'b0, 8'h30, 8'h00, lat, rd);
        check("abort_old_data", {24'd0, rd}, 32'h00000066);

        // LATENCY=0 unit.
        data_acc(1, 1'b1, 8'h05, 8'hA5, lat, rd);
        check("l0_wr_lat", lat, 2);
        data_acc(1, 1'b1, 8'h06, 8'h5A, lat, rd);
        inst_fetch(1, 8'h05, lat, ins);
        check("l0_fetch_lat", lat, 3);
        check("l0_fetch_data", {16'd0, ins}, 32'h0000A55A);

        // Held request: RESP, TURN, IDLE, BYTE, RESP -> 4 cycles between readies.
        d_req[1] = 1'b1; d_we[1] = 1'b0; d_addr[1] = 8'h06;
        n = 0;
        do begin tick(); n++; end while (!d_ready[1] && n < 60);
        check("l0_rd_lat", n, 2);
        check("l0_rd_data", {24'd0, d_rdata[1]}, 32'h0000005A);
        n = 0;
        do begin tick(); n++; end while (!d_ready[1] && n < 60);
        check("l0_turn_gap", n, 4);
        d_req[1] = 1'b0;
        tick(); tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
Name: mem_responder

Overview:
- Memory-side responder for the core's req/ready memory protocol; the fetch unit and the load/store unit are the initiators.
- Serves two initiator ports, instruction (i_) and data (d_), from one byte-wide backing store.
- Arbitrates round-robin between the two ports, inserts a programmable number of wait states per byte access, and assembles 16-bit instructions from two byte reads.

Parameters:
- M_WIDTH, 8: address width and data byte width.
- INST_WIDTH, 16: instruction width; must equal 2*M_WIDTH.
- LATENCY, 2: wait cycles per byte access, range 0..15.

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- i_req  in  1  instruction read request; level, held until i_ready
- i_addr  in  M_WIDTH  instruction byte address
- i_data  out  INST_WIDTH  instruction read data
- i_ready  out  1  one-cycle completion pulse, instruction port
- d_req  in  1  data request; level, held until d_ready
- d_we  in  1  1 = write, 0 = read
- d_addr  in  M_WIDTH  data byte address
- d_wdata  in  M_WIDTH  write data
- d_rdata  out  M_WIDTH  read data
- d_ready  out  1  one-cycle completion pulse, data port

Behaviour:
- Storage: 2^M_WIDTH bytes. Contents are not cleared by reset.
- Reset (rst==0 at a clk edge):
  - state=IDLE, wait counter=0, i_ready=0, d_ready=0, i_data=0, d_rdata=0.
  - last_grant=DATA, so the instruction port wins the first tie.
- States: IDLE, WAIT, BYTE, RESP, TURN.
- IDLE:
  - Sample i_req and d_req.
  - If exactly one is set, grant that port.
  - If both are set, grant the port that is not last_grant.
  - On grant: latch addr, we and wdata; set byte index=0 and counter=LATENCY; go to WAIT if LATENCY>0, otherwise go to BYTE.
- WAIT: decrement counter; when it reaches 1, go to BYTE.
- BYTE (one cycle, performs the access):
  - Data read: d_rdata <= mem[addr].
  - Data write: mem[addr] <= wdata.
  - Instruction, byte 0: i_data[15:8] <= mem[addr], then re-enter WAIT/BYTE for byte 1.
  - Instruction, byte 1: i_data[7:0] <= mem[(addr+1) mod 2^M_WIDTH]. Instructions are big-endian and the address wraps 0xFF -> 0x00.
  - After the last byte, go to RESP.
- RESP: assert the granted port's ready for exactly one cycle; update last_grant; go to TURN.
- TURN: one idle cycle so the initiator can drop req; requests are not sampled; go to IDLE.
- Latency, counted from the IDLE cycle that grants to the ready cycle, inclusive of the grant cycle:
  - Data access: LATENCY+2 cycles.
  - Instruction access: 2*LATENCY+3 cycles.
- Data validity:
  - i_data is valid in the i_ready cycle and held until the next instruction transaction overwrites it.
  - The same rule applies to d_rdata with d_ready; writes do not change d_rdata.
  - Back-to-back accesses on the same port are separated by at least RESP+TURN.
- Request rules:
  - addr/we/wdata changes after grant are ignored.
  - If req drops before ready, the transaction still completes and still pulses ready.
  - A request arriving while the other port is being served waits in IDLE; there is no starvation because arbitration is round-robin.
- Reset mid-operation: the transaction is aborted and no ready pulse is issued. A write is committed only if its BYTE cycle edge occurred before reset.
- Address arithmetic is modulo 2^M_WIDTH; no out-of-range condition exists.

Decomposition:
- Shared package mem_pkg holds:
  - the state enum (IDLE, WAIT, BYTE, RESP, TURN);
  - the port-select enum (INST, DATA);
  - localparam LAT_W=4.
- Sub-module byte_ram holds the storage: 2^M_WIDTH x M_WIDTH, synchronous write, asynchronous read, parameterised on M_WIDTH.
- mem_responder contains the FSM, arbiter, latches and output registers.

Test Plan:
- Setup: LATENCY=2. Write d_addr=0x10 d_wdata=0xAB, then 0x11 <- 0xCD. Each d_ready comes exactly 4 cycles after grant. Then fetch i_addr=0x10: i_ready 7 cycles after grant, i_data=0xABCD, held stable afterwards.
- Write 0xFF <- 0x12 and 0x00 <- 0x34, then fetch 0xFF -> i_data=0x1234 (address wraps).
- i_req and d_req raised in the same cycle straight after reset -> instruction port granted first, data port second. Repeat the tie -> grant alternates (DATA, then INST).
- Data read 0x10 after the first write -> d_rdata=0xAB. Then write 0x20 <- 0x55 -> d_rdata still 0xAB.
- Start a write 0x30 <- 0x77; assert rst=0 during WAIT -> no d_ready, outputs zero. Read 0x30 after reset -> old contents, not 0x77.
- With LATENCY=0 -> data access ready 2 cycles after grant, instruction access 3 cycles; the TURN cycle between consecutive grants is always present.
